// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: byte-delivery interface between the UART receiver and
// its consumer.
//   rx_data     received byte, stable while rx_valid is high
//   rx_valid    byte available, held until accepted
//   rx_ready    consumer accepts when rx_valid && rx_ready
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun_err one-cycle pulse, completed byte dropped
// master = receiver side, slave = consumer side.
interface uart_rx_os16_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling 8N1 UART receiver clocked by the uart_pll
// output. Each bit is decided by a 2-of-3 majority around mid-bit.
//   refclk      clock (uart_pll outclk_0)
//   rst         synchronous active-high reset
//   pll_locked  low aborts reception and holds the FSM in IDLE
//   rxd         asynchronous serial input, idle high
//   busy        high whenever the FSM is not IDLE
//   rx_if       byte handshake and error pulses (master side)
module uart_rx_os16 #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            refclk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic            rxd,
    output logic            busy,
    uart_rx_os16_if.master  rx_if
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] C_LO   = CW'(M - 1);
    localparam logic [CW-1:0] C_MID  = CW'(M);
    localparam logic [CW-1:0] C_HI   = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   samp_a;
    logic                   samp_b;

    logic maj;
    logic decide;
    logic wrap;
    logic complete;
    logic ferr;

    assign rxd_s = sync[SYNC_STAGES-1];
    assign busy  = (state != IDLE);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        complete   = 1'b0;
        ferr       = 1'b0;
        decide     = (cnt == C_HI);
        wrap       = (cnt == C_LAST);
        maj        = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
        unique case (state)
            IDLE: begin
                if (!rxd_s) next_state = START;
            end
            START: begin
                // A high majority at mid-bit means the falling edge was noise.
                if (decide && maj) next_state = IDLE;
                else if (wrap)     next_state = DATA;
            end
            DATA: begin
                if (wrap && (bit_idx == B_LAST)) next_state = STOP;
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (decide) begin
                    if (maj) begin
                        next_state = IDLE;
                        complete   = 1'b1;
                    end else begin
                        next_state = BREAK;
                        ferr       = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (!pll_locked) begin
            next_state = IDLE;
            complete   = 1'b0;
            ferr       = 1'b0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync              <= '1;
            cnt               <= '0;
            bit_idx           <= '0;
            shreg             <= '0;
            samp_a            <= 1'b1;
            samp_b            <= 1'b1;
            rx_if.rx_data     <= '0;
            rx_if.rx_valid    <= 1'b0;
            rx_if.frame_err   <= 1'b0;
            rx_if.overrun_err <= 1'b0;
        end else begin
            sync[0] <= rxd;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end

            if (cnt == C_LO)  samp_a <= rxd_s;
            if (cnt == C_MID) samp_b <= rxd_s;

            if (!pll_locked) begin
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= '0;
            end else begin
                unique case (state)
                    START, DATA, STOP: cnt <= wrap ? '0 : cnt + 1'b1;
                    default:           cnt <= '0;
                endcase
                if (state == START && wrap) begin
                    bit_idx <= '0;
                end else if (state == DATA && wrap && bit_idx != B_LAST) begin
                    bit_idx <= bit_idx + 1'b1;
                end
                if (state == DATA && decide) begin
                    if (DATA_BITS > 1) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    else               shreg <= maj;
                end
            end

            rx_if.frame_err   <= ferr;
            rx_if.overrun_err <= complete && rx_if.rx_valid && !rx_if.rx_ready;

            // Acceptance in the completion cycle frees the slot for the new byte.
            if (complete) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data  <= shreg;
                    rx_if.rx_valid <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 16x-oversampling UART receiver. It is clocked by the 1.843198 MHz uart_pll output (115200 baud x 16) and is the consuming end of that clock.
- Deserialises 8N1 frames from the board RX pin.
- Delivers bytes on a valid/ready interface to the chess command parser.
- Flags framing and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first
OVERSAMPLE, 16, clocks per bit; must be even and >= 8
SYNC_STAGES, 2, flops in the rxd input synchroniser

Ports:
refclk  in  1  clock, driven from uart_pll outclk_0
rst  in  1  synchronous, active-high reset
pll_locked  in  1  uart_pll locked; low aborts reception
rxd  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received byte, stable while rx_valid high
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun_err  out  1  one-cycle pulse: completed byte dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a refclk edge):
  - State goes to IDLE; synchroniser flops preset to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
- Synchroniser: rxd passes through SYNC_STAGES flops. rxd_s is the last stage; all decisions use rxd_s.
- Bit timing:
  - cnt runs 0..OVERSAMPLE-1 and wraps; bit index runs 0..DATA_BITS-1.
  - Each bit is decided by a 2-of-3 majority of rxd_s at cnt = M-1, M, M+1, where M = OVERSAMPLE/2.
  - The decision is taken at cnt = M+1.
- FSM states:
  - IDLE: on rxd_s==0, go to START with cnt=0 in that same cycle.
  - START: at the cnt=M+1 decision, a majority of 1 is a glitch; go to IDLE. A majority of 0 continues to DATA after the wrap, with bit index 0.
  - DATA: at each decision, shift the majority bit into the shift register (LSB first). After bit DATA_BITS-1 wraps, go to STOP.
  - STOP, decision 1: go to IDLE immediately (before the bit ends) and complete the byte.
  - STOP, decision 0: pulse frame_err and discard the byte. Go to BREAK.
  - BREAK: wait for rxd_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: rx_valid rises in the cycle following the stop decision. That is 16*(DATA_BITS+1)+M+2 = 154 refclk cycles after START cnt=0 (defaults), plus SYNC_STAGES from the pin.
- Output handshake:
  - rx_valid/rx_data change only on completion, acceptance or reset.
  - Acceptance: rx_valid && rx_ready clears rx_valid next cycle.
  - Completion with rx_valid low: load rx_data, set rx_valid.
  - Completion with rx_valid high and rx_ready low: old byte kept, new byte dropped, overrun_err pulses once.
  - Completion in the same cycle as acceptance: new byte loaded, rx_valid stays high, no overrun.
- pll_locked low:
  - Forces the FSM to IDLE and clears cnt, bit index and shift register.
  - No frame_err, no completion.
  - rx_valid/rx_data are retained and the handshake still operates.
  - Reception resumes with the first start edge seen after pll_locked returns high.
- rst mid-frame: the partial frame is lost. Reception restarts only on a new falling edge after rst is released. If rxd is already low, the FSM enters START immediately; the START glitch check handles an invalid start.
- frame_err and overrun_err are never asserted together.

Test Plan:
- Send 0xA5 (8N1, 16 clocks/bit), rx_ready=1 -> rx_data=0xA5 and rx_valid high 1 cycle, rising 154 cycles after START cnt=0; no error pulses.
- rxd low for 4 cycles then high -> START aborts at cnt=9; busy returns low; no rx_valid, no frame_err.
- Send 0x3C with stop bit low, then hold rxd low for 40 bit times, then 0x81 -> exactly one frame_err, no valid for 0x3C; 0x81 received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun_err pulses once at the second completion. Then rx_ready=1 -> 0x11 accepted, rx_valid low.
- Back-to-back 0x55,0xAA with rx_ready pulsed in the exact completion cycle of 0xAA -> 0xAA loaded, no overrun. Separately, a one-cycle inverted spike at cnt=8 of bit 3 of 0x0F -> majority rejects it, rx_data=0x0F.
- pll_locked dropped at bit 4 of 0x77, restored, then send 0x99 -> no completion or error for 0x77; 0x99 received. rst asserted mid-frame -> all outputs 0 next cycle.
